// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the shared memory port and the
// pipeline controller. "master" is the arbiter's view, "slave" the environment's.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction fetch requester
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_done;
  logic [DATA_W-1:0] inst_rdata;

  // Data access requester
  logic              data_req;
  logic [3:0]        data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_done;
  logic [DATA_W-1:0] data_rdata;

  // Shared memory port
  logic              mem_req;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  // Pipeline controller
  logic              stall_req;

  modport master (
    input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
           mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_done, inst_rdata, data_done, data_rdata,
           mem_req, mem_wen, mem_addr, mem_wdata, stall_req
  );

  modport slave (
    output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
           mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_done, inst_rdata, data_done, data_rdata,
           mem_req, mem_wen, mem_addr, mem_wdata, stall_req
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SRAM-like memory port between instruction
// fetch and data access, serialised through an address-phase/data-phase FSM.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_DATA = 1
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  logic   owner;       // 0 = inst, 1 = data
  logic   last_grant;  // 0 = inst, 1 = data
  logic   grant_data;
  logic   finish;

  // On a tie the requester that did not win last time gets the port.
  assign grant_data = bus.data_req & (~bus.inst_req | ~last_grant);

  // NOTE: completion is decoded combinationally from state and mem_data_ok
  // with continuous assigns, so every output has a value on every path and
  // no latch can be inferred.
  assign finish         = (state == DATA) & bus.mem_data_ok;
  assign bus.inst_done  = finish & ~owner;
  assign bus.data_done  = finish & owner;
  assign bus.inst_rdata = bus.inst_done ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.data_rdata = bus.data_done ? bus.mem_rdata : {DATA_W{1'b0}};

  assign bus.stall_req = (bus.inst_req & ~bus.inst_done) |
                         (bus.data_req & ~bus.data_done);

  // mem_wen/mem_addr/mem_wdata double as the latched transaction registers,
  // so requester inputs cannot disturb an in-flight access.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= (PRIO_DATA == 0);
      bus.mem_req   <= 1'b0;
      bus.mem_wen   <= 4'b0000;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (bus.inst_req | bus.data_req) begin
            owner         <= grant_data;
            last_grant    <= grant_data;
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= grant_data ? bus.data_addr  : bus.inst_addr;
            bus.mem_wen   <= grant_data ? bus.data_wen   : 4'b0000;
            bus.mem_wdata <= grant_data ? bus.data_wdata : {DATA_W{1'b0}};
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (bus.mem_addr_ok) begin
            bus.mem_req <= 1'b0;
            state       <= DATA;
          end
        end
        DATA: begin
          if (bus.mem_data_ok) begin
            state <= IDLE;
          end
        end
        default: begin
          bus.mem_req <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter, checked against a
// transaction-level reference model of the shared memory port.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_DATA(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one optional in-flight transaction record.
  bit          m_busy, m_acc, m_own_d, m_last_d;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wen;
  bit          m_done_i, m_done_d;

  // Random-phase requester bookkeeping
  bit i_act, d_act, i_drop, d_drop;

  // Directed bookkeeping
  logic [31:0] gnt_addr [8];
  int          gnt_cyc  [8];
  int          n_gnt;
  bit          seen_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_acc    = 1'b0;
    m_own_d  = 1'b0;
    m_last_d = 1'b0;  // PRIO_DATA=1: last grant treated as inst
    m_done_i = 1'b0;
    m_done_d = 1'b0;
  endtask

  task automatic model_check();
    bit exp_req, ed_i, ed_d;
    exp_req = m_busy && !m_acc;
    ed_i    = m_busy && m_acc && bus.mem_data_ok && !m_own_d;
    ed_d    = m_busy && m_acc && bus.mem_data_ok && m_own_d;
    check("mem_req", bus.mem_req, exp_req);
    if (exp_req) begin
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_wen", bus.mem_wen, m_wen);
      check("mem_wdata", bus.mem_wdata, m_wdata);
    end
    check("inst_done", bus.inst_done, ed_i);
    check("data_done", bus.data_done, ed_d);
    check("inst_rdata", bus.inst_rdata, ed_i ? bus.mem_rdata : 32'h0);
    check("data_rdata", bus.data_rdata, ed_d ? bus.mem_rdata : 32'h0);
    check("stall_req", bus.stall_req,
          (bus.inst_req && !ed_i) || (bus.data_req && !ed_d));
    m_done_i = ed_i;
    m_done_d = ed_d;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    bit gd;
    if (!m_busy) begin
      if (bus.inst_req || bus.data_req) begin
        if (bus.inst_req && bus.data_req) gd = !m_last_d;
        else                              gd = bus.data_req;
        m_busy   = 1'b1;
        m_acc    = 1'b0;
        m_own_d  = gd;
        m_last_d = gd;
        m_addr   = gd ? bus.data_addr  : bus.inst_addr;
        m_wen    = gd ? bus.data_wen   : 4'b0000;
        m_wdata  = gd ? bus.data_wdata : 32'h0;
      end
    end else if (!m_acc) begin
      if (bus.mem_addr_ok) m_acc = 1'b1;
    end else if (bus.mem_data_ok) begin
      m_busy = 1'b0;
    end
  endtask

  // Called at a falling edge after inputs are driven; returns at the next one.
  task automatic step();
    #1;
    model_check();
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = 32'h0;
    bus.data_req    = 1'b0;
    bus.data_wen    = 4'h0;
    bus.data_addr   = 32'h0;
    bus.data_wdata  = 32'h0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    do_reset();

    // Reset state
    #1;
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_stall", bus.stall_req, 1'b0);
    @(negedge clk);

    // 1: single fetch, addr_ok at c1, data_ok at c3
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0000;
    #1; check("t1_c0_req", bus.mem_req, 1'b0); check("t1_c0_stall", bus.stall_req, 1'b1);
    step();
    bus.mem_addr_ok = 1'b1;
    #1; check("t1_c1_req", bus.mem_req, 1'b1); check("t1_c1_addr", bus.mem_addr, 32'hBFC0_0000);
    check("t1_c1_wen", bus.mem_wen, 4'h0);
    step();
    bus.mem_addr_ok = 1'b0;
    #1; check("t1_c2_req", bus.mem_req, 1'b0); check("t1_c2_done", bus.inst_done, 1'b0);
    check("t1_c2_stall", bus.stall_req, 1'b1);
    step();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h2408_0001;
    #1; check("t1_c3_done", bus.inst_done, 1'b1); check("t1_c3_rdata", bus.inst_rdata, 32'h2408_0001);
    check("t1_c3_stall", bus.stall_req, 1'b0);
    step();
    bus.inst_req = 1'b0; bus.mem_data_ok = 1'b0;
    #1; check("t1_c4_done", bus.inst_done, 1'b0); check("t1_c4_rdata", bus.inst_rdata, 32'h0);
    step();

    // 2+3: first tie after reset goes to data, then strict alternation
    do_reset();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_1000;
    bus.data_req = 1'b1; bus.data_addr = 32'h0000_2000;
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h55AA_55AA;
    n_gnt = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (bus.mem_req && n_gnt < 8) begin
        gnt_addr[n_gnt] = bus.mem_addr;
        gnt_cyc[n_gnt]  = k;
        n_gnt++;
      end
      step();
    end
    check("t3_n_grants", n_gnt, 4);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("t3_grant%0d_addr", g), gnt_addr[g], (g % 2 == 0) ? 32'h2000 : 32'h1000);
      check($sformatf("t3_grant%0d_cyc", g), gnt_cyc[g], 1 + 3 * g);
    end
    clear_inputs();
    step();

    // 4: delayed address acceptance, inst_addr changes while held
    do_reset();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h100;
    step();
    for (int j = 0; j < 5; j++) begin
      bus.inst_addr = 32'h200;
      #1; check($sformatf("t4_hold%0d_req", j), bus.mem_req, 1'b1);
      check($sformatf("t4_hold%0d_addr", j), bus.mem_addr, 32'h100);
      step();
    end
    bus.mem_addr_ok = 1'b1;
    #1; check("t4_acc_addr", bus.mem_addr, 32'h100);
    step();
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    #1; check("t4_done", bus.inst_done, 1'b1);
    step();
    clear_inputs();
    step();

    // 5: store
    bus.data_req = 1'b1; bus.data_wen = 4'hF;
    bus.data_addr = 32'h8000_1000; bus.data_wdata = 32'hDEAD_BEEF;
    #1; check("t5_c0_rdata", bus.data_rdata, 32'h0);
    step();
    bus.mem_addr_ok = 1'b1;
    #1; check("t5_wen", bus.mem_wen, 4'hF); check("t5_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("t5_addr", bus.mem_addr, 32'h8000_1000);
    step();
    bus.mem_addr_ok = 1'b0; bus.mem_rdata = 32'h1234_5678;
    #1; check("t5_c2_done", bus.data_done, 1'b0); check("t5_c2_rdata", bus.data_rdata, 32'h0);
    step();
    bus.mem_data_ok = 1'b1;
    #1; check("t5_c3_done", bus.data_done, 1'b1); check("t5_c3_rdata", bus.data_rdata, 32'h1234_5678);
    step();
    clear_inputs();
    step();

    // 6: reset during DATA, late data_ok ignored, then a normal fetch
    bus.inst_req = 1'b1; bus.inst_addr = 32'h300;
    step();
    bus.mem_addr_ok = 1'b1;
    step();
    bus.mem_addr_ok = 1'b0;
    #2; rst_n = 1'b0; bus.inst_req = 1'b0;
    #1; check("t6_rst_req", bus.mem_req, 1'b0); check("t6_rst_done", bus.inst_done, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    #1; check("t6_late_idone", bus.inst_done, 1'b0); check("t6_late_ddone", bus.data_done, 1'b0);
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h400; bus.mem_addr_ok = 1'b1; bus.mem_rdata = 32'h600D_600D;
    seen_done = 1'b0;
    for (int w = 0; w < 10 && !seen_done; w++) begin
      #1;
      if (bus.inst_done) begin
        seen_done = 1'b1;
        check("t6_rdata", bus.inst_rdata, 32'h600D_600D);
      end
      step();
    end
    check("t6_done_seen", seen_done, 1'b1);
    clear_inputs();
    step();

    // Randomized traffic against the reference model
    do_reset();
    i_act = 0; d_act = 0; i_drop = 0; d_drop = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_done_i) begin i_act = 0; i_drop = 0; end
      if (m_done_d) begin d_act = 0; d_drop = 0; end
      if (!i_act) begin
        if ($urandom_range(0, 2) == 0) begin
          i_act = 1; bus.inst_req = 1'b1; bus.inst_addr = $urandom & 32'hFFFF_FFFC;
        end else begin
          bus.inst_req = 1'b0; bus.inst_addr = $urandom;
        end
      end else if (!i_drop && m_busy && !m_own_d && $urandom_range(0, 15) == 0) begin
        i_drop = 1; bus.inst_req = 1'b0;
      end
      if (!d_act) begin
        if ($urandom_range(0, 2) == 0) begin
          d_act = 1; bus.data_req = 1'b1; bus.data_addr = $urandom & 32'hFFFF_FFFC;
          bus.data_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          bus.data_wdata = $urandom;
        end else begin
          bus.data_req = 1'b0; bus.data_addr = $urandom;
          bus.data_wen = 4'($urandom_range(0, 15)); bus.data_wdata = $urandom;
        end
      end else if (!d_drop && m_busy && m_own_d && $urandom_range(0, 15) == 0) begin
        d_drop = 1; bus.data_req = 1'b0;
      end
      bus.mem_addr_ok = 1'($urandom_range(0, 1));
      bus.mem_data_ok = ($urandom_range(0, 2) != 0);
      bus.mem_rdata   = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single SRAM-like memory port between two requesters: instruction fetch (IF PC-driven reads) and data access (MEM-stage loads/stores).
- Serialises transactions through an address-phase/data-phase FSM, with round-robin fairness when both requesters are active.
- Raises a stall request to the pipeline controller while either requester is waiting.
- Sits between the IF/MEM stages and the external memory/bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- PRIO_DATA, 1: 1 = data wins the first tie after reset; 0 = inst wins.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- inst_req  in  1  instruction read request; level, held until inst_done.
- inst_addr  in  ADDR_W  fetch address.
- inst_done  out  1  one-cycle completion pulse.
- inst_rdata  out  DATA_W  fetched word; valid while inst_done=1.
- data_req  in  1  data request; level, held until data_done.
- data_wen  in  4  byte write enables; 0 = read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_done  out  1  one-cycle completion pulse.
- data_rdata  out  DATA_W  load word; valid while data_done=1.
- mem_req  out  1  memory request.
- mem_wen  out  4  byte enables to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_addr_ok  in  1  memory accepted the address phase.
- mem_data_ok  in  1  memory completed the data phase.
- mem_rdata  in  DATA_W  memory read data.
- stall_req  out  1  pipeline stall request.

Behaviour:
- **FSM states:** IDLE, ADDR, DATA. Registers: owner (0=inst, 1=data), last_grant, latched wen/addr/wdata.

- **Reset (rst_n=0, asynchronous):**
  - state=IDLE; mem_req=0; mem_wen/mem_addr/mem_wdata=0; owner=0.
  - last_grant = inst if PRIO_DATA=1, else data.
  - Effect is immediate, including mid-transaction. Any later mem_addr_ok/mem_data_ok from the aborted transaction is ignored, and no done pulse is produced.

- **IDLE:**
  - If exactly one request is asserted, grant it.
  - If both are asserted, grant the one not equal to last_grant.
  - On grant: latch that requester's addr/wen/wdata (inst wen forced to 0, wdata to 0), set owner and last_grant, go to ADDR.
  - No request: stay in IDLE.

- **ADDR:**
  - mem_req=1; mem_* driven from latched registers only, so changes on requester inputs do not affect an in-flight transaction.
  - mem_addr_ok=1: go to DATA next cycle.
  - Otherwise hold mem_req and all mem_* stable.

- **DATA:**
  - mem_req=0.
  - mem_data_ok=1 (combinational):
    - owner's done=1;
    - owner's rdata = mem_rdata;
    - next state = IDLE.
  - Otherwise wait with no timeout.

- **Done/rdata outputs:**
  - inst_done/data_done are 0 outside the DATA+mem_data_ok cycle.
  - inst_rdata/data_rdata are 0 when their done is 0.

- **Ignored inputs:**
  - mem_data_ok is ignored in IDLE and ADDR.
  - mem_addr_ok is ignored in IDLE and DATA.

- **Latency:** minimum 3 cycles, request to done. Example: req sampled in IDLE at c0, ADDR at c1 with addr_ok, DATA at c2 with data_ok and done at c2.

- **Back-to-back:** the requester deasserts req, or presents a new request, in the cycle after done. IDLE re-arbitrates at that point, giving 1 idle cycle between transactions.

- **Dropped request:** a requester dropping req after grant does not cancel the transaction; it completes and done still pulses.

- **stall_req** = (inst_req & ~inst_done) | (data_req & ~data_done), combinational; 0 at reset when both reqs are 0.

- **Fairness:** with both requests held continuously, grants strictly alternate.

Test Plan:
1. **Single fetch:** inst_req=1, inst_addr=0xBFC00000, addr_ok at c1, data_ok+mem_rdata=0x24080001 at c3 -> mem_req=1 only c1, mem_addr=0xBFC00000, mem_wen=0, inst_done=1 and inst_rdata=0x24080001 only c3, stall_req=1 c0–c2, 0 at c3.
2. **First tie after reset, PRIO_DATA=1:** inst_req=data_req=1 -> first mem_addr=data_addr; second transaction is inst.
3. **Continuous tie, 4 transactions:** both reqs held with immediate addr_ok/data_ok -> grant order D,I,D,I; one IDLE cycle between each.
4. **Delayed address acceptance:** addr_ok withheld 5 cycles while inst_addr changes 0x100->0x200 -> mem_req held 5 cycles, mem_addr stays 0x100.
5. **Store:** data_wen=4'b1111, data_addr=0x80001000, data_wdata=0xDEADBEEF -> mem_wen=4'b1111, mem_wdata=0xDEADBEEF in ADDR; data_done pulses on data_ok; data_rdata=0 outside the pulse.
6. **Reset during DATA:** rst_n=0 -> mem_req=0 immediately; after release, a late data_ok in IDLE produces no done; next inst_req completes normally.
